// File: rtl/fetch_pkg.sv
// Shared Y86-64 fetch definitions: opcode and status codes, FSM encoding, opcode classifiers.
package fetch_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    StFetch0,
    StRegb,
    StConst,
    StDone,
    StStop
  } fetch_state_e;

  function automatic logic need_regids(input logic [3:0] icode);
    case (icode)
      ICODE_RRMOVQ, ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ,
      ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic need_valC(input logic [3:0] icode);
    case (icode)
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_JXX, ICODE_CALL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic instr_valid(input logic [3:0] icode, input logic [3:0] ifun);
    if (icode > ICODE_POPQ) return 1'b0;
    case (icode)
      ICODE_RRMOVQ, ICODE_JXX: return (ifun <= 4'd6);
      ICODE_OPQ:               return (ifun <= 4'd3);
      ICODE_RET:               return (ifun == 4'd0);
      default:                 return (ifun == 4'd0);
    endcase
  endfunction

endpackage

// File: rtl/y86_instr_class.sv
// Combinational opcode classifier: register-byte need, constant need and legality of icode/ifun.
module y86_instr_class
  import fetch_pkg::*;
(
  input  logic [3:0] icode_i,
  input  logic [3:0] ifun_i,
  output logic       need_regids_o,
  output logic       need_valc_o,
  output logic       valid_o
);

  assign need_regids_o = need_regids(icode_i);
  assign need_valc_o   = need_valC(icode_i);
  assign valid_o       = instr_valid(icode_i, ifun_i);

endmodule

// File: rtl/fetch_sequencer.sv
// Y86-64 multi-cycle fetch: byte-wide req/ack memory in, valid/ready instruction out.
// Optional FETCH_TIMEOUT_EN abandons a request left unacknowledged for TIMEOUT_CYCLES cycles.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_err,
  input  logic        pc_load,
  input  logic [63:0] pc_new,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat
);

  fetch_state_e state_q;
  logic [63:0]  pc_q, target_q, valc_q, valp_q;
  logic [3:0]   off_q, icode_q, ifun_q, ra_q, rb_q;
  logic [2:0]   k_q, stat_q;
  logic         req_q, valid_q, drain_q;

  logic         timeout, ack_ev, err_ev, outstanding, restart;
  logic [63:0]  restart_pc, valp_calc;
  logic [3:0]   cls_icode, cls_ifun, ilen;
  logic         nr, nc, iv;

`ifdef FETCH_TIMEOUT_EN
  logic [31:0] wait_q;

  assign timeout = req_q && !mem_ack && (wait_q == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= '0;
    end else if (!req_q || mem_ack || timeout) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_q + 32'd1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // A timeout behaves like an ack carrying mem_err.
  assign ack_ev      = req_q && (mem_ack || timeout);
  assign err_ev      = req_q && ((mem_ack && mem_err) || timeout);
  assign outstanding = req_q && !ack_ev;

  assign restart    = (pc_load && !outstanding) || (drain_q && ack_ev);
  assign restart_pc = pc_load ? pc_new : target_q;

  // Opcode byte is classified straight off the bus; later bytes use the latched opcode.
  assign cls_icode = (state_q == StFetch0) ? mem_rdata[7:4] : icode_q;
  assign cls_ifun  = (state_q == StFetch0) ? mem_rdata[3:0] : ifun_q;

  y86_instr_class u_class (
    .icode_i       (cls_icode),
    .ifun_i        (cls_ifun),
    .need_regids_o (nr),
    .need_valc_o   (nc),
    .valid_o       (iv)
  );

  assign ilen      = 4'd1 + {3'b000, nr} + (nc ? 4'd8 : 4'd0);
  assign valp_calc = pc_q + {60'd0, ilen};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StFetch0;
      pc_q     <= RESET_PC;
      target_q <= '0;
      off_q    <= '0;
      k_q      <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      drain_q  <= 1'b0;
      icode_q  <= '0;
      ifun_q   <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      valc_q   <= '0;
      valp_q   <= '0;
      stat_q   <= STAT_AOK;
    end else if (restart) begin
      state_q <= StFetch0;
      pc_q    <= restart_pc;
      off_q   <= '0;
      k_q     <= '0;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
      drain_q <= 1'b0;
      icode_q <= '0;
      ifun_q  <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      valc_q  <= '0;
      valp_q  <= '0;
      stat_q  <= STAT_AOK;
    end else if (pc_load) begin
      // Request in flight: keep it on the bus, remember where to go once it completes.
      drain_q  <= 1'b1;
      target_q <= pc_new;
    end else if (!drain_q) begin
      unique case (state_q)
        StFetch0: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (ack_ev) begin
            off_q  <= 4'd1;
            k_q    <= '0;
            ra_q   <= 4'hF;
            rb_q   <= 4'hF;
            valc_q <= '0;
            valp_q <= valp_calc;
            if (err_ev) begin
              icode_q <= ICODE_NOP;
              ifun_q  <= 4'h0;
              stat_q  <= STAT_ADR;
              state_q <= StDone;
              valid_q <= 1'b1;
              req_q   <= 1'b0;
            end else begin
              icode_q <= mem_rdata[7:4];
              ifun_q  <= mem_rdata[3:0];
              if (!iv) begin
                stat_q  <= STAT_INS;
                state_q <= StDone;
                valid_q <= 1'b1;
                req_q   <= 1'b0;
              end else begin
                stat_q <= (mem_rdata[7:4] == ICODE_HALT) ? STAT_HLT : STAT_AOK;
                if (nr) begin
                  state_q <= StRegb;
                end else if (nc) begin
                  state_q <= StConst;
                end else begin
                  state_q <= StDone;
                  valid_q <= 1'b1;
                  req_q   <= 1'b0;
                end
              end
            end
          end
        end
        StRegb: begin
          if (ack_ev) begin
            if (err_ev) begin
              icode_q <= ICODE_NOP;
              ifun_q  <= 4'h0;
              stat_q  <= STAT_ADR;
              state_q <= StDone;
              valid_q <= 1'b1;
              req_q   <= 1'b0;
            end else begin
              ra_q  <= mem_rdata[7:4];
              rb_q  <= mem_rdata[3:0];
              off_q <= off_q + 4'd1;
              if (nc) begin
                state_q <= StConst;
              end else begin
                state_q <= StDone;
                valid_q <= 1'b1;
                req_q   <= 1'b0;
              end
            end
          end
        end
        StConst: begin
          if (ack_ev) begin
            if (err_ev) begin
              icode_q <= ICODE_NOP;
              ifun_q  <= 4'h0;
              stat_q  <= STAT_ADR;
              state_q <= StDone;
              valid_q <= 1'b1;
              req_q   <= 1'b0;
            end else begin
              valc_q[{k_q, 3'b000} +: 8] <= mem_rdata;
              off_q <= off_q + 4'd1;
              k_q   <= k_q + 3'd1;
              if (k_q == 3'd7) begin
                state_q <= StDone;
                valid_q <= 1'b1;
                req_q   <= 1'b0;
              end
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (stat_q == STAT_AOK) begin
              pc_q    <= valp_q;
              off_q   <= '0;
              req_q   <= 1'b1;
              state_q <= StFetch0;
            end else begin
              state_q <= StStop;
            end
          end
        end
        StStop: begin
          req_q <= 1'b0;
        end
        default: begin
          state_q <= StStop;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = pc_q + {60'd0, off_q};
  assign out_valid = valid_q;
  assign icode     = icode_q;
  assign ifun      = ifun_q;
  assign rA        = ra_q;
  assign rB        = rb_q;
  assign valC      = valc_q;
  assign valP      = valp_q;
  assign stat      = stat_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: zero-wait byte memory model, redirects, errors, reset.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset_n;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        mem_err;
  logic        pc_load;
  logic [63:0] pc_new;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic [2:0]  stat;

  logic [7:0]  mem [0:4095];
  logic        ack_on;
  logic        err_on;
  logic [63:0] err_addr;
  int          ack_cnt;
  int          checks;
  int          errors;

  fetch_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err),
    .pc_load   (pc_load),
    .pc_new    (pc_new),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .icode     (icode),
    .ifun      (ifun),
    .rA        (rA),
    .rB        (rB),
    .valC      (valC),
    .valP      (valP),
    .stat      (stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ack   = mem_req && ack_on;
  assign mem_rdata = mem[mem_addr[11:0]];
  assign mem_err   = mem_ack && err_on && (mem_addr == err_addr);

  always @(posedge clk) if (mem_req && mem_ack) ack_cnt <= ack_cnt + 1;

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] target);
    pc_load = 1'b1;
    pc_new  = target;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: mem_req=%b out_valid=%b, want 0 0", mem_req, out_valid);
    end
    checks++;
    if (icode !== 4'h0 || rA !== 4'h0 || valC !== 64'h0 || valP !== 64'h0 || stat !== 3'd1) begin
      errors++;
      $display("FAIL reset_fields: icode=%h rA=%h valC=%h valP=%h stat=%0d, want 0 0 0 0 1",
               icode, rA, valC, valP, stat);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_byte;
    int n;
    wait_valid(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL nop_latency: cycles=%0d, want 2", n);
    end
    checks++;
    if (icode !== 4'h1 || ifun !== 4'h0 || rA !== 4'hF || rB !== 4'hF || valC !== 64'h0 ||
        valP !== 64'h1 || stat !== 3'd1) begin
      errors++;
      $display("FAIL nop_fields: icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h stat=%0d", icode,
               ifun, rA, rB, valC, valP, stat);
    end
    handshake();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL nop_next: mem_req=%b mem_addr=%h out_valid=%b, want 1 1 0", mem_req,
               mem_addr, out_valid);
    end
  endtask

  task automatic test_irmovq;
    int n;
    // Redirect lands in the ack cycle of the byte at 1, which is discarded.
    redirect(64'h100);
    wait_valid(n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL irmovq_latency: cycles=%0d, want 10", n);
    end
    checks++;
    if (icode !== 4'h3 || ifun !== 4'h0 || rA !== 4'hF || rB !== 4'h3 || stat !== 3'd1) begin
      errors++;
      $display("FAIL irmovq_regs: icode=%h ifun=%h rA=%h rB=%h stat=%0d, want 3 0 F 3 1",
               icode, ifun, rA, rB, stat);
    end
    checks++;
    if (valC !== 64'h0102030405060708 || valP !== 64'h10A) begin
      errors++;
      $display("FAIL irmovq_vals: valC=%h valP=%h, want 0102030405060708 10a", valC, valP);
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || mem_req !== 1'b0 || icode !== 4'h3 ||
          valC !== 64'h0102030405060708 || valP !== 64'h10A) begin
        errors++;
        $display("FAIL stall_hold: cyc=%0d out_valid=%b mem_req=%b icode=%h valC=%h valP=%h",
                 i, out_valid, mem_req, icode, valC, valP);
      end
    end
    handshake();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h10A) begin
      errors++;
      $display("FAIL stall_next: mem_req=%b mem_addr=%h, want 1 10a", mem_req, mem_addr);
    end
  endtask

  task automatic test_halt_ins;
    int n;
    int base;
    wait_valid(n);
    checks++;
    if (n !== 1 || icode !== 4'h0 || stat !== 3'd2) begin
      errors++;
      $display("FAIL halt: cycles=%0d icode=%h stat=%0d, want 1 0 2", n, icode, stat);
    end
    handshake();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt_stop: mem_req=%b out_valid=%b, want 0 0", mem_req, out_valid);
      end
    end
    base = ack_cnt;
    redirect(64'h120);
    wait_valid(n);
    checks++;
    if (n !== 1 || icode !== 4'hC || stat !== 3'd4 || (ack_cnt - base) !== 1) begin
      errors++;
      $display("FAIL ins: cycles=%0d icode=%h stat=%0d bytes=%0d, want 1 c 4 1", n, icode,
               stat, ack_cnt - base);
    end
    handshake();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ins_stop: mem_req=%b out_valid=%b, want 0 0", mem_req, out_valid);
    end
  endtask

  task automatic test_adr;
    int n;
    err_addr = 64'h142;
    err_on   = 1'b1;
    redirect(64'h140);
    wait_valid(n);
    checks++;
    if (n !== 3 || icode !== 4'h1 || ifun !== 4'h0 || stat !== 3'd3) begin
      errors++;
      $display("FAIL adr: cycles=%0d icode=%h ifun=%h stat=%0d, want 3 1 0 3", n, icode, ifun,
               stat);
    end
    handshake();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL adr_stop: mem_req=%b, want 0", mem_req);
    end
    err_on = 1'b0;
  endtask

  task automatic test_drain;
    int n;
    ack_on = 1'b0;
    redirect(64'h160);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h160) begin
      errors++;
      $display("FAIL drain_start: mem_req=%b mem_addr=%h, want 1 160", mem_req, mem_addr);
    end
    redirect(64'h180);
    redirect(64'h200);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h160 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_hold: mem_req=%b mem_addr=%h out_valid=%b, want 1 160 0", mem_req,
               mem_addr, out_valid);
    end
    ack_on = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h200) begin
      errors++;
      $display("FAIL drain_target: mem_req=%b mem_addr=%h, want 1 200", mem_req, mem_addr);
    end
    wait_valid(n);
    checks++;
    if (n !== 1 || icode !== 4'h1 || stat !== 3'd1) begin
      errors++;
      $display("FAIL drain_fetch: cycles=%0d icode=%h stat=%0d, want 1 1 1", n, icode, stat);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    ack_on = 1'b0;
    redirect(64'h240);
    wait_valid(n);
    checks++;
    if (n !== 16 || icode !== 4'h1 || ifun !== 4'h0 || stat !== 3'd3 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout: cycles=%0d icode=%h ifun=%h stat=%0d mem_req=%b, want 16 1 0 3 0",
               n, icode, ifun, stat, mem_req);
    end
    ack_on = 1'b1;
  endtask
`endif

  task automatic test_reset_mid;
    redirect(64'h100);
    repeat (3) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h103) begin
      errors++;
      $display("FAIL mid_const: mem_req=%b mem_addr=%h, want 1 103", mem_req, mem_addr);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || out_valid !== 1'b0 || mem_addr !== 64'h0 || icode !== 4'h0 ||
        valC !== 64'h0 || stat !== 3'd1) begin
      errors++;
      $display("FAIL async_reset: mem_req=%b out_valid=%b mem_addr=%h icode=%h valC=%h stat=%0d",
               mem_req, out_valid, mem_addr, icode, valC, stat);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ack_cnt   = 0;
    ack_on    = 1'b1;
    err_on    = 1'b0;
    err_addr  = '0;
    pc_load   = 1'b0;
    pc_new    = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h000] = 8'h10;
    mem[12'h001] = 8'h10;
    mem[12'h100] = 8'h30;
    mem[12'h101] = 8'hF3;
    for (int i = 0; i < 8; i++) mem[12'h102 + i] = 8'(8 - i);
    mem[12'h120] = 8'hC0;
    mem[12'h140] = 8'h40;
    mem[12'h141] = 8'h12;
    mem[12'h200] = 8'h10;

    test_reset();
    test_single_byte();
    test_irmovq();
    test_stall();
    test_halt_ins();
    test_adr();
    test_drain();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
